// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: datapath widths, the standard luminance
// quantization table and the zig-zag scan order.
package jpeg_pkg;

    localparam int JPEG_COEF_W = 12;
    localparam int JPEG_OUT_W  = 12;
    localparam int JPEG_QT_W   = 8;

    // Standard JPEG luminance quantization table, natural (raster) order.
    localparam logic [7:0] LUMA_QT [64] = '{
        8'd16, 8'd11, 8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
    };

    // Zig-zag position -> natural index.
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/zigzag_rom.sv
// Combinational zig-zag position to natural (raster) index lookup.
module zigzag_rom
    import jpeg_pkg::*;
(
    input  logic [5:0] zz,
    output logic [5:0] nat
);

    assign nat = ZIGZAG[zz];

endmodule

// File: rtl/dequantization.sv
// Decoder-side dequantizer: multiplies each incoming coefficient by its
// quantization-table entry, saturates, and tags it with its raster index.
module dequantization
    import jpeg_pkg::*;
#(
    parameter int COEF_W    = JPEG_COEF_W,
    parameter int OUT_W     = JPEG_OUT_W,
    parameter int QT_W      = JPEG_QT_W,
    parameter bit ZIGZAG_IN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_coef,
    output logic [5:0]        out_index,
    output logic              out_last,
    input  logic              qt_we,
    input  logic [5:0]        qt_addr,
    input  logic [QT_W-1:0]   qt_wdata,
    output logic              qt_busy
);

    localparam int PROD_W = COEF_W + QT_W + 1;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [5:0]               idx;
    logic [5:0]               nat;
    logic [QT_W-1:0]          qt_table [64];
    logic                     in_fire;
    logic                     out_fire;
    logic                     qt_write;
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] qt_ext;
    logic signed [PROD_W-1:0] prod;
    logic [OUT_W-1:0]         sat_coef;

    // The output register can always take a new beat once its current one leaves.
    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = out_valid && out_ready;
    assign qt_busy  = (idx != 6'd0) || out_valid;
    assign qt_write = qt_we && !qt_busy;

    generate
        if (ZIGZAG_IN) begin : g_zigzag
            zigzag_rom u_zigzag_rom (
                .zz  (idx),
                .nat (nat)
            );
        end else begin : g_natural
            assign nat = idx;
        end
    endgenerate

    // Full-width signed product of coefficient and table entry, clamped to OUT_W.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sat_coef = '0;
        coef_ext = {{(PROD_W - COEF_W){in_coef[COEF_W-1]}}, in_coef};
        qt_ext   = {{(PROD_W - QT_W){1'b0}}, qt_table[nat]};
        prod     = coef_ext * qt_ext;
        if (prod > SAT_MAX) begin
            sat_coef = SAT_MAX[OUT_W-1:0];
        end else if (prod < SAT_MIN) begin
            sat_coef = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_coef = prod[OUT_W-1:0];
        end
    end

    // Quantization table: defaults on reset, writable only between blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this table is deliberately reset (to the standard luminance values),
            // so it is built from flops rather than an inferable RAM macro.
            for (int i = 0; i < 64; i++) begin
                qt_table[i] <= QT_W'(LUMA_QT[i]);
            end
        end else if (qt_write) begin
            qt_table[qt_addr] <= qt_wdata;
        end
    end

    // Coefficient counter and single output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            idx       <= 6'd0;
            out_valid <= 1'b0;
            out_coef  <= '0;
            out_index <= 6'd0;
            out_last  <= 1'b0;
        end else if (flush) begin
            idx       <= 6'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (in_fire) begin
            idx       <= idx + 6'd1;
            out_valid <= 1'b1;
            out_coef  <= sat_coef;
            out_index <= nat;
            out_last  <= (idx == 6'd63);
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule
